// File: rtl/timer_tick_driver_if.sv
// Bus between the tick driver (initiator) and the memory-mapped timer, with
// the request/grant pair shared with the CPU.
interface timer_tick_driver_if;
    logic        bus_req;
    logic        bus_grant;
    logic [31:0] address;
    logic [31:0] data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] cycle;
    logic        TimerInterrupt;
    logic        TimerAddress;

    modport master (
        output bus_req, address, data, MemRead, MemWrite,
        input  bus_grant, cycle, TimerInterrupt, TimerAddress
    );

    modport slave (
        input  bus_req, address, data, MemRead, MemWrite,
        output bus_grant, cycle, TimerInterrupt, TimerAddress
    );
endinterface

// File: rtl/timer_tick_driver.sv
// Bus initiator that runs the timer read/program/ack loop in hardware and
// emits a drift-free periodic tick with a running tick count.
//
// state  | meaning
// IDLE   | disarmed, waiting for enable
// READ   | read current cycle count, cmp = count + period
// WRITE  | program interrupt-cycle register with cmp
// WAIT   | off the bus, waiting for TimerInterrupt or enable drop
// ACK    | clear TimerInterrupt, issue tick, advance cmp by one period
// DISARM | push interrupt-cycle register out of reach
// CLR    | clear any interrupt that raced the disarm
module timer_tick_driver #(
    parameter logic [31:0] CYCLE_ADDR = 32'hffff001c,
    parameter logic [31:0] ACK_ADDR   = 32'hffff006c,
    parameter logic [31:0] MIN_PERIOD = 32'd4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [31:0]                period,
    timer_tick_driver_if.master        bus,
    output logic                       tick,
    output logic [31:0]                tick_count,
    output logic                       busy,
    output logic                       err
);
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WRITE, S_WAIT, S_ACK, S_DISARM, S_CLR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cmp_q, cmp_d;
    logic        tick_q, tick_d;
    logic [31:0] tick_count_q, tick_count_d;
    logic        err_q, err_d;
    logic [31:0] p_eff;
    logic        in_txn;

    assign p_eff = (period < MIN_PERIOD) ? MIN_PERIOD : period;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cmp_q        <= '0;
            tick_q       <= 1'b0;
            tick_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmp_q        <= cmp_d;
            tick_q       <= tick_d;
            tick_count_q <= tick_count_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cmp_d        = cmp_q;
        tick_d       = 1'b0;
        tick_count_d = tick_count_q;
        err_d        = err_q | (in_txn & bus.bus_grant & ~bus.TimerAddress);
        case (state_q)
            S_IDLE:   if (enable) state_d = S_READ;
            S_READ:   if (bus.bus_grant) begin
                          cmp_d   = bus.cycle + p_eff;
                          state_d = S_WRITE;
                      end
            S_WRITE:  if (bus.bus_grant) state_d = S_WAIT;
            S_WAIT:   if (bus.TimerInterrupt) state_d = S_ACK;
                      else if (!enable)       state_d = S_DISARM;
            // Rearm from the previous compare value, not a fresh read, so ticks never drift.
            S_ACK:    if (bus.bus_grant) begin
                          tick_d       = 1'b1;
                          tick_count_d = tick_count_q + 32'd1;
                          cmp_d        = cmp_q + p_eff;
                          state_d      = enable ? S_WRITE : S_IDLE;
                      end
            S_DISARM: if (bus.bus_grant) state_d = S_CLR;
            S_CLR:    if (bus.bus_grant) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_txn       = (state_q != S_IDLE) && (state_q != S_WAIT);
        busy         = (state_q != S_IDLE);
        bus.bus_req  = in_txn;
        bus.address  = '0;
        bus.data     = '0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        if (bus.bus_grant) begin
            case (state_q)
                S_READ: begin
                    bus.MemRead = 1'b1;
                    bus.address = CYCLE_ADDR;
                end
                S_WRITE: begin
                    bus.MemWrite = 1'b1;
                    bus.address  = CYCLE_ADDR;
                    bus.data     = cmp_q;
                end
                S_ACK, S_CLR: begin
                    bus.MemWrite = 1'b1;
                    bus.address  = ACK_ADDR;
                end
                S_DISARM: begin
                    bus.MemWrite = 1'b1;
                    bus.address  = CYCLE_ADDR;
                    bus.data     = 32'hffffffff;
                end
                default: ;
            endcase
        end
    end

    assign tick       = tick_q;
    assign tick_count = tick_count_q;
    assign err        = err_q;
endmodule

// File: tb/tb_timer_tick_driver.sv
// Directed bench for timer_tick_driver: a behavioural timer answers the bus,
// and each step checks outputs against hand-computed values.
module tb_timer_tick_driver;
    localparam logic [31:0] CYCLE_ADDR = 32'hffff001c;
    localparam logic [31:0] ACK_ADDR   = 32'hffff006c;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] period;
    logic        grant;
    logic        force_ta0;
    logic        cnt_load;
    logic [31:0] cnt_val;
    logic        tick;
    logic [31:0] tick_count;
    logic        busy;
    logic        err;

    logic [31:0] t_cnt, t_cmp;
    logic        t_irq;

    int          cyc;
    int          rd_cyc;
    logic [31:0] rd_val;
    logic [31:0] cw_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    timer_tick_driver_if bus ();

    timer_tick_driver dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .period     (period),
        .bus        (bus.master),
        .tick       (tick),
        .tick_count (tick_count),
        .busy       (busy),
        .err        (err)
    );

    always #5 clock = ~clock;

    assign bus.bus_grant      = grant;
    assign bus.cycle          = t_cnt;
    assign bus.TimerInterrupt = t_irq;
    assign bus.TimerAddress   = !force_ta0 &&
                                ((bus.address == CYCLE_ADDR) || (bus.address == ACK_ADDR));

    // Timer: free-running counter, interrupt latched when counter equals compare.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            t_cnt <= '0;
            t_cmp <= 32'hffffffff;
            t_irq <= 1'b0;
        end else begin
            t_cnt <= cnt_load ? cnt_val : t_cnt + 32'd1;
            if (bus.MemWrite && bus.address == ACK_ADDR) t_irq <= 1'b0;
            else if (t_cnt == t_cmp)                      t_irq <= 1'b1;
            if (bus.MemWrite && bus.address == CYCLE_ADDR) t_cmp <= bus.data;
        end
    end

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && bus.MemRead) begin
            rd_val <= t_cnt;
            rd_cyc <= cyc;
        end
        if (!reset && bus.MemWrite && bus.address == CYCLE_ADDR) cw_q.push_back(bus.data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            @(negedge clock);
            if (tick) at = cyc;
        end
        chk("tick_timeout", 32'(at >= 0), 32'd1);
    endtask

    // sel 0: WAIT state, 1: granted write to CYCLE_ADDR, 2: granted write to ACK_ADDR
    task automatic wait_for(input int sel, input int budget, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clock);
            case (sel)
                0: ok = busy && !bus.bus_req;
                1: ok = bus.MemWrite && bus.address == CYCLE_ADDR;
                default: ok = bus.MemWrite && bus.address == ACK_ADDR;
            endcase
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic disarm();
        wait_for(0, 60, "disarm_wait");
        enable = 1'b0;
        repeat (3) @(negedge clock);
        chk("disarm_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int t1, t2, t3, n0, bad, irqs, ticks;
        cyc       = 0;
        reset     = 1'b1;
        enable    = 1'b1;
        period    = 32'd10;
        grant     = 1'b1;
        force_ta0 = 1'b0;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tick_count", tick_count, 32'd0);
        chk("rst_bus_req", 32'(bus.bus_req), 32'd0);
        chk("rst_address", bus.address, 32'd0);
        chk("rst_strobes", {30'd0, bus.MemRead, bus.MemWrite}, 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Period 10, grant always high: first READ sees count 1.
        n0 = cw_q.size();
        reset = 1'b0;
        wait_tick(40, t1);
        chk("t1_read_val", rd_val, 32'd1);
        chk("t1_latency", 32'(t1 - rd_cyc), 32'd13);
        chk("t1_count", tick_count, 32'd1);
        wait_tick(20, t2);
        chk("t2_interval", 32'(t2 - t1), 32'd10);
        chk("t2_count", tick_count, 32'd2);
        wait_tick(20, t3);
        chk("t3_interval", 32'(t3 - t2), 32'd10);
        chk("t3_count", tick_count, 32'd3);
        chk("cmp_wr0", cw_q[n0], 32'd11);
        chk("cmp_wr1", cw_q[n0 + 1], 32'd21);
        chk("cmp_wr2", cw_q[n0 + 2], 32'd31);

        // Enable dropped in WAIT: disarm write, clear write, then idle.
        wait_for(0, 10, "t4_wait");
        enable = 1'b0;
        @(negedge clock);
        chk("t4_dis_we", 32'(bus.MemWrite), 32'd1);
        chk("t4_dis_addr", bus.address, CYCLE_ADDR);
        chk("t4_dis_data", bus.data, 32'hffffffff);
        @(negedge clock);
        chk("t4_clr_we", 32'(bus.MemWrite), 32'd1);
        chk("t4_clr_addr", bus.address, ACK_ADDR);
        @(negedge clock);
        chk("t4_idle", 32'(busy), 32'd0);
        irqs = 0;
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (t_irq) irqs++;
            if (tick) ticks++;
        end
        chk("t4_no_irq", 32'(irqs), 32'd0);
        chk("t4_no_tick", 32'(ticks), 32'd0);
        chk("t4_count", tick_count, 32'd3);

        // Period 1 clamps to 4; 21 ticks with every gap exactly 4.
        period = 32'd1;
        enable = 1'b1;
        wait_tick(30, t1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            wait_tick(10, t2);
            if (t2 - t1 != 4) bad++;
            t1 = t2;
        end
        chk("t2_bad_gaps", 32'(bad), 32'd0);
        chk("t2_count", tick_count, 32'd24);
        disarm();

        // Grant withheld for three READ cycles.
        grant  = 1'b0;
        period = 32'd20;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("t3_stall_req", 32'(bus.bus_req), 32'd1);
            chk("t3_stall_rd", 32'(bus.MemRead), 32'd0);
            chk("t3_stall_addr", bus.address, 32'd0);
        end
        @(negedge clock);
        grant = 1'b1;
        #1;
        chk("t3_held_rd", 32'(bus.MemRead), 32'd1);
        chk("t3_held_addr", bus.address, CYCLE_ADDR);
        wait_tick(40, t1);
        chk("t3_latency", 32'(t1 - rd_cyc), 32'd23);
        wait_tick(30, t2);
        chk("t3_interval", 32'(t2 - t1), 32'd20);
        chk("t3_count", tick_count, 32'd26);
        disarm();

        // Compare value wraps past 2^32.
        grant  = 1'b0;
        period = 32'd10;
        enable = 1'b1;
        @(negedge clock);
        cnt_load = 1'b1;
        cnt_val  = 32'hfffffffa;
        @(negedge clock);
        cnt_load = 1'b0;
        grant    = 1'b1;
        @(negedge clock);
        chk("t5_wr_we", 32'(bus.MemWrite), 32'd1);
        chk("t5_wr_data", bus.data, 32'h00000004);
        wait_tick(30, t1);
        chk("t5_latency", 32'(t1 - rd_cyc), 32'd13);
        chk("t5_count", tick_count, 32'd27);
        disarm();

        // Decode error on a granted WRITE, then async reset mid-ACK.
        chk("t6_err_pre", 32'(err), 32'd0);
        enable = 1'b1;
        wait_for(1, 10, "t6_wait_write");
        force_ta0 = 1'b1;
        @(negedge clock);
        force_ta0 = 1'b0;
        chk("t6_err_set", 32'(err), 32'd1);
        wait_for(2, 40, "t6_wait_ack");
        chk("t6_err_sticky", 32'(err), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("t6_rst_req", 32'(bus.bus_req), 32'd0);
        chk("t6_rst_we", 32'(bus.MemWrite), 32'd0);
        chk("t6_rst_addr", bus.address, 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_count", tick_count, 32'd0);
        chk("t6_rst_err", 32'(err), 32'd0);
        chk("t6_rst_tick", 32'(tick), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
